// File: rtl/sm_pkg.sv
// Shared types and constants for the signed_multiplier sequencer, its datapath and benches.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : sm_pkg

// File: rtl/sm_controller.sv
// Control FSM sequencing a shift-and-add signed_multiplier datapath (IDLE/LOAD/ITER/DONE).
// Optional early termination on a zero multiplicand: define SM_CTRL_EARLY_TERM_EN.
module sm_controller
    import sm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic zflag,
    input  logic lsb_multiplicand,
    output logic load,
    output logic shift_en,
    output logic reg_en,
    output logic psel,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

`ifdef SM_CTRL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_zterm;

    // zflag only matters when early termination is compiled in.
    assign w_zterm = EARLY_TERM & zflag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        load         = 1'b0;
        shift_en     = 1'b0;
        reg_en       = 1'b0;
        psel         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                end
            end

            LOAD: begin
                busy         = 1'b1;
                load         = 1'b1;
                reg_en       = 1'b1;
                w_next_cnt   = CNT_INIT;
                w_next_state = ITER;
            end

            ITER: begin
                busy = 1'b1;
                psel = 1'b1;
                if (w_zterm) begin
                    w_next_state = DONE;
                end else begin
                    shift_en = 1'b1;
                    reg_en   = lsb_multiplicand;
                    // Hold at 1 on the last iteration instead of wrapping.
                    if (r_cnt <= CNT_LAST) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_cnt = r_cnt - CNT_LAST;
                    end
                end
            end

            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule : sm_controller

// File: tb/tb_sm_controller.sv
// Randomized scoreboard bench for sm_controller against a timeline reference model.
module tb_sm_controller;
    import sm_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic zflag = 1'b0;
    logic lsb = 1'b0;
    logic load, shift_en, reg_en, psel, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_k is the number of edges since the accepted start (-1 = idle).
    int edge_cnt = 0;
    int m_k = -1;
    int exp_done_q[$];

    always #5 clk = ~clk;

    sm_controller #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .zflag            (zflag),
        .lsb_multiplicand (lsb),
        .load             (load),
        .shift_en         (shift_en),
        .reg_en           (reg_en),
        .psel             (psel),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t edge=%0d: got %0d expected %0d", name, $time, edge_cnt, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic l, input logic z);
        @(posedge clk);
        #1;
        start = s;
        lsb   = l;
        zflag = z;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_reg_en"}, reg_en, 0);
        chk({tag, "_psel"}, psel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = -1;
            exp_done_q.delete();
        end else begin
            edge_cnt++;
            if (m_k == -1) begin
                if (start) begin
                    m_k = 0;
                    exp_done_q.push_back(edge_cnt + W);
                end
            end else if (m_k == W) begin
                m_k = -1;
`ifdef SM_CTRL_EARLY_TERM_EN
            end else if (m_k >= 1 && m_k <= W - 1 && zflag) begin
                m_k = W;
                exp_done_q[0] = edge_cnt;
`endif
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        logic it;
        logic early;
        int   e;
        it = (m_k >= 1 && m_k <= W - 1);
`ifdef SM_CTRL_EARLY_TERM_EN
        early = it && zflag;
`else
        early = 1'b0;
`endif
        chk("load", load, (m_k == 0));
        chk("shift_en", shift_en, (it && !early));
        chk("reg_en", reg_en, ((m_k == 0) || (it && !early && lsb)));
        chk("psel", psel, it);
        chk("busy", busy, (m_k >= 0));
        chk("done_level", done, (m_k == W));
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = exp_done_q.pop_front();
                chk("done_cycle", edge_cnt, e);
            end
        end
    end

    initial begin
        logic [6:0] pat;
        pat = 7'b0000101;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        rst_n = 1'b1;

        // Single op with reg_en following lsb pattern 1,0,1,0,0,0,0.
        drive(1, 0, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, pat[i], 0);
        drive(0, 0, 0);
        drive(0, 0, 0);

        // Start pulses mid-operation must be ignored.
        drive(1, 0, 0);
        for (int c = 1; c <= W + 2; c++) drive((c == 3 || c == 6), 1'($urandom_range(0, 1)), 0);

        // zflag in the second ITER cycle.
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        for (int c = 0; c < W + 2; c++) drive(0, 1, 0);

        // Start held high: back-to-back operations.
        for (int c = 0; c < 2 * (W + 2) + 2; c++) drive(1, 1'($urandom_range(0, 1)), 0);
        for (int c = 0; c < W + 2; c++) drive(0, 0, 0);

        // Async reset in cycle 4 of an operation.
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0);
        for (int c = 0; c < W + 2; c++) drive(0, 1'($urandom_range(0, 1)), 0);

        // Randomized traffic with one mid-run async reset.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            if (i == 403) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk_all_zero("rand_rst");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        for (int c = 0; c < W + 3; c++) drive(0, 0, 0);
        chk("sb_drain", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sm_controller

// File: doc/sm_controller.md
SM_CONTROLLER -- requirements
Module: sm_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of the signed_multiplier datapath it sequences.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start, input, 1 bit: request one multiplication; sampled only in IDLE.
REQ-005 SHALL have port zflag, input, 1 bit: datapath flag, remaining multiplicand magnitude is zero.
REQ-006 SHALL have port lsb_multiplicand, input, 1 bit: current multiplicand LSB from the datapath.
REQ-007 SHALL have port load, output, 1 bit: load operand registers in the datapath.
REQ-008 SHALL have port shift_en, output, 1 bit: shift multiplier left and multiplicand right.
REQ-009 SHALL have port reg_en, output, 1 bit: product register write enable.
REQ-010 SHALL have port psel, output, 1 bit: product input select; 0 = clear to zero, 1 = adder output.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse; product is valid.

Function
REQ-013 SHALL implement the states IDLE, LOAD, ITER and DONE.
REQ-014 IDLE: start=1 SHALL move the FSM to LOAD; start=0 SHALL keep it in IDLE.
REQ-015 LOAD: outputs SHALL be load=1, reg_en=1, psel=0, shift_en=0; iteration counter SHALL be set to WIDTH-1; next state SHALL be ITER.
REQ-016 ITER outputs SHALL be shift_en=1, psel=1, load=0, reg_en=lsb_multiplicand; reg_en is the only Mealy output.
REQ-017 ITER SHALL decrement the counter each cycle and SHALL move to DONE in the cycle the counter reaches 1.
REQ-018 DONE: outputs SHALL be done=1 and all datapath enables 0; next state SHALL be IDLE unconditionally.
REQ-019 Latency for WIDTH=8, with start sampled at edge 0: LOAD in cycle 1, ITER in cycles 2-8 (7 iterations), done=1 in cycle 9.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high through DONE SHALL start a new operation from IDLE; back-to-back throughput is WIDTH+2 cycles.
REQ-022 The counter SHALL be $clog2(WIDTH) bits and SHALL NOT wrap below 1.
REQ-023 In IDLE all outputs except busy SHALL be 0, and busy SHALL also be 0.

Reset
REQ-024 rst_n=0 SHALL force the FSM to IDLE and the counter to 0 immediately, regardless of clk.
REQ-025 During reset, load, shift_en, reg_en, psel, busy and done SHALL all be 0.
REQ-026 Reset asserted mid-operation SHALL abandon it with no done pulse; the first start after release SHALL begin a fresh LOAD.

Configuration
REQ-027 With SM_CTRL_EARLY_TERM_EN defined, ITER with zflag=1 SHALL go directly to DONE, with shift_en=0 and reg_en=0 in that cycle.
REQ-028 Without SM_CTRL_EARLY_TERM_EN, zflag SHALL be ignored and every operation SHALL take exactly WIDTH-1 ITER cycles.

Structure
REQ-029 The state enum (IDLE, LOAD, ITER, DONE) and the constant DEFAULT_WIDTH=8 SHALL live in shared package sm_pkg, also used by the datapath and benches.
REQ-030 The block SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-031 Reset, then start pulse with multiplier=-5 and multiplicand=5 on the connected signed_multiplier -> done in cycle 9, product magnitude 25, sign=1.
REQ-032 lsb_multiplicand pattern 1,0,1,0,0,0,0 during ITER -> reg_en follows exactly 1,0,1,0,0,0,0 while shift_en=1 throughout.
REQ-033 start pulsed in cycles 3 and 6 of a running operation -> no extra LOAD and exactly one done pulse.
REQ-034 rst_n low in cycle 4 of an operation -> all outputs 0 asynchronously, state IDLE, no done pulse; next start gives done 9 cycles later.
REQ-035 Macro defined, zflag=1 in the second ITER cycle -> done in cycle 4; macro undefined with the same stimulus -> done in cycle 9.
